// File: rtl/axi_read_slave_mem.sv
// rtl/axi_read_slave_mem.sv - AXI4 read-channel slave serving FIXED/INCR/WRAP bursts from a preloadable word memory
module axi_read_slave_mem #(
    parameter int MEM_WORDS  = 256,
    parameter int RD_LATENCY = 2
) (
    input  logic                         G_clk,
    input  logic                         G_reset,
    input  logic [31:0]                  S_ARADDR,
    input  logic [3:0]                   S_ARLEN,
    input  logic [2:0]                   S_ARSIZE,
    input  logic [1:0]                   S_ARBURST,
    input  logic                         S_ARVALID,
    output logic                         S_ARREADY,
    output logic [31:0]                  S_RDATA,
    output logic [1:0]                   S_RRESP,
    output logic                         S_RLAST,
    output logic                         S_RVALID,
    input  logic                         S_RREADY,
    input  logic [31:0]                  addr_lo,
    input  logic [31:0]                  addr_hi,
    input  logic                         mem_we,
    input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
    input  logic [31:0]                  mem_wdata
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LAT  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  beat;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  lat_cnt;
    logic        bad_req;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] step;
    logic [31:0] container;
    logic [31:0] wrap_mask;
    logic [4:0]  len_p1;
    logic        wrap_ok;
    logic [31:0] next_addr;
    logic        advancing;
    logic [31:0] fetch_addr;
    logic [3:0]  fetch_beat;
    logic [31:0] word_off;
    logic [AW-1:0] fetch_idx;
    logic        fetch_err;
    logic        fetch_last;
    logic        unused_off_bits;
    logic        req_bad;

    // Illegal request attributes are judged once at acceptance and poison every beat.
    always_comb begin
        req_bad = (S_ARSIZE > 3'd2) || (S_ARBURST == 2'b11) ||
                  ((S_ARBURST == BURST_WRAP) &&
                   !((S_ARLEN == 4'd1) || (S_ARLEN == 4'd3) ||
                     (S_ARLEN == 4'd7) || (S_ARLEN == 4'd15)));
    end

    always_comb begin
        step      = 32'd1 << size;
        len_p1    = {1'b0, len} + 5'd1;
        container = {27'd0, len_p1} << size;
        wrap_mask = container - 32'd1;
        wrap_ok   = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        next_addr = addr + step;
        if (burst == BURST_FIXED) begin
            next_addr = addr;
        end else if ((burst == BURST_WRAP) && wrap_ok) begin
            next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
        end
    end

    // One memory read port: either the first beat (current addr) or the beat after an accepted one.
    always_comb begin
        advancing  = (state == DATA) && S_RVALID && S_RREADY && (beat != len);
        fetch_addr = advancing ? next_addr : addr;
        fetch_beat = advancing ? beat + 4'd1 : beat;
        word_off   = (fetch_addr - addr_lo) >> 2;
        fetch_idx  = word_off[AW-1:0];
        fetch_err  = bad_req || (fetch_addr < addr_lo) || (fetch_addr > addr_hi);
        fetch_last = (fetch_beat == len);
    end

    assign unused_off_bits = ^word_off[31:AW];

    // Preload only while idle so a burst never observes data changing under it.
    always_ff @(posedge G_clk) begin
        if (mem_we && (state == IDLE)) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge G_clk or negedge G_reset) begin
        if (!G_reset) begin
            state     <= IDLE;
            S_ARREADY <= 1'b0;
            S_RVALID  <= 1'b0;
            S_RLAST   <= 1'b0;
            S_RRESP   <= RESP_OKAY;
            S_RDATA   <= 32'd0;
            addr      <= 32'd0;
            len       <= 4'd0;
            beat      <= 4'd0;
            size      <= 3'd0;
            burst     <= 2'd0;
            lat_cnt   <= 4'd0;
            bad_req   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    S_ARREADY <= 1'b1;
                    if (S_ARVALID && S_ARREADY) begin
                        addr      <= S_ARADDR;
                        len       <= S_ARLEN;
                        size      <= S_ARSIZE;
                        burst     <= S_ARBURST;
                        bad_req   <= req_bad;
                        beat      <= 4'd0;
                        lat_cnt   <= LAT_INIT;
                        S_ARREADY <= 1'b0;
                        state     <= (RD_LATENCY == 0) ? DATA : LAT;
                    end
                end
                LAT: begin
                    if (lat_cnt <= 4'd1) begin
                        state <= DATA;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                DATA: begin
                    // Entering DATA with RVALID low means the first beat still has to be fetched.
                    if (!S_RVALID || advancing) begin
                        S_RVALID <= 1'b1;
                        S_RDATA  <= fetch_err ? 32'd0 : mem[fetch_idx];
                        S_RRESP  <= fetch_err ? RESP_SLVERR : RESP_OKAY;
                        S_RLAST  <= fetch_last;
                        if (advancing) begin
                            addr <= next_addr;
                            beat <= beat + 4'd1;
                        end
                    end else if (S_RREADY) begin
                        S_RVALID  <= 1'b0;
                        S_RLAST   <= 1'b0;
                        S_RRESP   <= RESP_OKAY;
                        S_RDATA   <= 32'd0;
                        S_ARREADY <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    S_ARREADY <= 1'b0;
                    S_RVALID  <= 1'b0;
                    S_RLAST   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_slave_mem.sv
// tb/tb_axi_read_slave_mem.sv - scoreboard bench for axi_read_slave_mem with a burst-level reference model
module tb_axi_read_slave_mem;

    localparam int LAT = 2;
    localparam logic [31:0] LO = 32'h1000_0000;
    localparam logic [31:0] HI = 32'h1000_03FF;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;

    logic [1:0]  rr_mode;
    logic        rr_force;
    logic        rr_rnd = 1'b1;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    beat_t       exp_q[$];
    int          lat_q[$];
    logic [31:0] mdl [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1;
        rr_rnd = ($urandom_range(0, 3) != 0);
    end
    assign rready = (rr_mode == 2'd0) ? 1'b1 : (rr_mode == 2'd1) ? rr_rnd : rr_force;

    axi_read_slave_mem #(.MEM_WORDS(256), .RD_LATENCY(LAT)) dut (
        .G_clk(clk), .G_reset(rst_n),
        .S_ARADDR(araddr), .S_ARLEN(arlen), .S_ARSIZE(arsize), .S_ARBURST(arburst),
        .S_ARVALID(arvalid), .S_ARREADY(arready),
        .S_RDATA(rdata), .S_RRESP(rresp), .S_RLAST(rlast), .S_RVALID(rvalid), .S_RREADY(rready),
        .addr_lo(LO), .addr_hi(HI),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Reference: walk the burst address by address using the rules stated for AXI bursts.
    task automatic push_expected(input logic [31:0] a0, input int len, input int size, input int burst);
        logic [31:0] a, off, base, n, c;
        bit bad;
        beat_t e;
        a = a0;
        n = 32'd1 << size;
        c = 32'(len + 1) * n;
        bad = (size > 2) || (burst == 3) ||
              (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        for (int b = 0; b <= len; b++) begin
            off = a - LO;
            e.l = (b == len) ? 1'b1 : 1'b0;
            if (bad || a < LO || a > HI) begin
                e.d = 32'd0;
                e.r = 2'b10;
            end else begin
                e.d = mdl[off[9:2]];
                e.r = 2'b00;
            end
            exp_q.push_back(e);
            if (burst == 0) begin
                a = a;
            end else if (burst == 2 && !bad) begin
                base = a - (a % c);
                a = base + ((a - base + n) % c);
            end else begin
                a = a + n;
            end
        end
    endtask

    task automatic preload_word(input int i, input logic [31:0] d);
        mem_we = 1'b1;
        mem_waddr = i[7:0];
        mem_wdata = d;
        @(posedge clk);
        #1;
        mem_we = 1'b0;
        mdl[i] = d;
    endtask

    task automatic issue(input logic [31:0] a, input int len, input int size, input int burst);
        bit ok;
        araddr = a;
        arlen = 4'(len);
        arsize = 3'(size);
        arburst = 2'(burst);
        arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (arready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        chk("ar_handshake", 32'(ok), 32'd1);
        if (ok) begin
            lat_q.push_back(cyc);
            push_expected(a, len, size, burst);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        chk("burst_done", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares every accepted beat and watches handshake-level rules.
    bit    first_pend = 1'b1;
    bit    held_v = 1'b0;
    bit    chk_idle = 1'b0;
    beat_t held;
    always @(negedge clk) begin
        beat_t e;
        if (!rst_n) begin
            exp_q.delete();
            lat_q.delete();
            first_pend = 1'b1;
            held_v = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (chk_idle) begin
                chk("arready_after_last", 32'(arready), 32'd1);
                chk("rvalid_after_last", 32'(rvalid), 32'd0);
                chk_idle = 1'b0;
            end
            if (rvalid) begin
                chk("arready_during_burst", 32'(arready), 32'd0);
                if (held_v) begin
                    chk("hold_rdata", rdata, held.d);
                    chk("hold_rresp", 32'(rresp), 32'(held.r));
                    chk("hold_rlast", 32'(rlast), 32'(held.l));
                end
                if (first_pend) begin
                    if (lat_q.size() == 0) flag_fail("first_beat_without_request");
                    else chk("first_beat_latency", 32'(cyc - lat_q.pop_front()), 32'(LAT + 1));
                    first_pend = 1'b0;
                end
                if (rready) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        flag_fail("unexpected_beat");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", rdata, e.d);
                        chk("rresp", 32'(rresp), 32'(e.r));
                        chk("rlast", 32'(rlast), 32'(e.l));
                        if (e.l) begin
                            chk_idle = 1'b1;
                            first_pend = 1'b1;
                        end
                    end
                end else begin
                    held_v = 1'b1;
                    held.d = rdata;
                    held.r = rresp;
                    held.l = rlast;
                end
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int len, size, burst, sel;
        rst_n = 1'b0;
        araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
        rr_mode = 2'd0; rr_force = 1'b1;
        #2;
        chk("reset_arready", 32'(arready), 32'd0);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        chk("reset_rlast", 32'(rlast), 32'd0);
        chk("reset_rresp", 32'(rresp), 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arready_after_reset", 32'(arready), 32'd1);

        for (int i = 0; i < 256; i++) preload_word(i, 32'hA000_0000 + 32'(i));

        issue(32'h1000_0010, 3, 2, 1);
        wait_done();
        issue(32'h1000_0018, 3, 2, 2);
        wait_done();
        issue(32'h1000_0020, 2, 2, 0);
        wait_done();

        // Backpressure on beat 1 while a new request and a preload are attempted mid-burst.
        rr_mode = 2'd2;
        rr_force = 1'b1;
        issue(32'h1000_0010, 3, 2, 1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid) break;
        end
        @(posedge clk);
        #1;
        rr_force = 1'b0;
        araddr = 32'h1000_0100;
        arvalid = 1'b1;
        mem_we = 1'b1;
        mem_waddr = 8'd5;
        mem_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_rdata", rdata, 32'hA000_0005);
            chk("bp_rlast", 32'(rlast), 32'd0);
            chk("bp_arready", 32'(arready), 32'd0);
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        mem_we = 1'b0;
        rr_force = 1'b1;
        wait_done();
        rr_mode = 2'd0;
        issue(32'h1000_0014, 0, 2, 1);
        wait_done();

        issue(32'h1000_03FC, 1, 2, 1);
        wait_done();
        issue(32'h1000_0000, 1, 3, 1);
        wait_done();
        issue(32'h1000_0000, 0, 2, 3);
        wait_done();
        issue(32'h1000_0040, 2, 2, 2);
        wait_done();
        issue(32'h0FFF_FFF8, 3, 2, 1);
        wait_done();

        // Preload in the handshake cycle must be visible to that burst.
        mem_we = 1'b1;
        mem_waddr = 8'd9;
        mem_wdata = 32'h1234_5678;
        mdl[9] = 32'h1234_5678;
        issue(32'h1000_0024, 0, 2, 1);
        mem_we = 1'b0;
        wait_done();

        // Reset while beat 2 of an 8-beat burst is on the bus.
        issue(32'h1000_0000, 7, 2, 1);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() <= 6) break;
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_rvalid", 32'(rvalid), 32'd0);
        chk("midreset_rlast", 32'(rlast), 32'd0);
        chk("midreset_arready", 32'(arready), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("release_arready_before_edge", 32'(arready), 32'd0);
        @(posedge clk);
        #1;
        chk("release_arready_first_edge", 32'(arready), 32'd1);
        issue(32'h1000_0000, 0, 2, 1);
        wait_done();

        rr_mode = 2'd1;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 255);
                preload_word(sel, $urandom);
            end
            sel = $urandom_range(0, 9);
            if (sel == 0) a = LO - 32'h40 + 32'($urandom_range(0, 31)) * 4;
            else if (sel == 1) a = HI - 32'h1F + 32'($urandom_range(0, 15)) * 4;
            else a = LO + 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
            size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            len = $urandom_range(0, 15);
            if (size <= 2) a = a & ~((32'd1 << size) - 32'd1);
            issue(a, len, size, burst);
            wait_done();
        end
        rr_mode = 2'd0;

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
